// File: rtl/vx_perf_ctr_bank.sv
// vx_perf_ctr_bank
//   Bank of NUM_CTRS memory-system performance counters. Each channel adds a
//   per-cycle increment of up to 2^INC_WIDTH-1. On overflow a channel either
//   wraps or clamps at all-ones, depending on SATURATE, and sets a sticky
//   overflow flag. A snapshot copies all live counters at once. A single-entry
//   valid/ready read port returns snapshot values.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   enable            global count enable (gates increments only)
//   inc_valid/inc_amt per-channel increment strobe / amount (channel i at
//                     inc_amt[i*INC_WIDTH +: INC_WIDTH])
//   clear             zero live counters and overflow flags
//   snap              copy live counters into snapshot registers
//   ctr_live, ovf     registered live counters, sticky overflow flags
//   rd_req_*          read request (addr >= NUM_CTRS reads as 0)
//   rd_rsp_*          read response, 1-cycle latency, held under backpressure
module vx_perf_ctr_bank #(
    parameter int NUM_CTRS   = 16,
    parameter int CTR_WIDTH  = 44,
    parameter int INC_WIDTH  = 4,
    parameter int SATURATE   = 0,
    parameter int ADDR_WIDTH = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_CTRS-1:0]            inc_valid,
    input  logic [NUM_CTRS*INC_WIDTH-1:0]  inc_amt,
    input  logic                           clear,
    input  logic                           snap,
    output logic [NUM_CTRS*CTR_WIDTH-1:0]  ctr_live,
    output logic [NUM_CTRS-1:0]            ovf,
    input  logic                           rd_req_valid,
    input  logic [ADDR_WIDTH-1:0]          rd_req_addr,
    output logic                           rd_req_ready,
    output logic                           rd_rsp_valid,
    output logic [CTR_WIDTH-1:0]           rd_rsp_data,
    input  logic                           rd_rsp_ready
);

    logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] ctr_q, ctr_d;
    logic [NUM_CTRS-1:0][CTR_WIDTH-1:0] snap_q, snap_d;
    logic [NUM_CTRS-1:0]                ovf_q, ovf_d;
    logic [NUM_CTRS-1:0][CTR_WIDTH:0]   sum;
    logic                               rsp_valid_q, rsp_valid_d;
    logic [CTR_WIDTH-1:0]               rsp_data_q, rsp_data_d;
    logic [CTR_WIDTH-1:0]               rd_sel;
    logic                               rd_accept;

    // Counter update. The sum carries one extra bit so that its MSB is the
    // carry-out, which drives both the wrap/clamp choice and the overflow flag.
    always_comb begin
        ctr_d  = ctr_q;
        ovf_d  = ovf_q;
        snap_d = snap_q;
        sum    = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            sum[i] = {1'b0, ctr_q[i]}
                   + (CTR_WIDTH+1)'(inc_amt[i*INC_WIDTH +: INC_WIDTH]);
            // The snapshot takes the value from before this edge's increment or clear.
            if (snap)
                snap_d[i] = ctr_q[i];
            if (clear) begin
                ctr_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (enable && inc_valid[i]) begin
                if (sum[i][CTR_WIDTH]) begin
                    ovf_d[i] = 1'b1;
                    ctr_d[i] = (SATURATE != 0) ? {CTR_WIDTH{1'b1}} : sum[i][CTR_WIDTH-1:0];
                end else begin
                    ctr_d[i] = sum[i][CTR_WIDTH-1:0];
                end
            end
        end
    end

    // Address decode. An address with no matching channel reads as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (rd_req_addr == ADDR_WIDTH'(i))
                rd_sel = snap_q[i];
        end
    end

    assign rd_req_ready = !rsp_valid_q || rd_rsp_ready;
    assign rd_accept    = rd_req_valid && rd_req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_sel;
        end else if (rd_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q       <= '0;
            snap_q      <= '0;
            ovf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ctr_q       <= ctr_d;
            snap_q      <= snap_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign ctr_live     = ctr_q;
    assign ovf          = ovf_q;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;

endmodule
